// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the four raw stopwatch board inputs
// and decodes them into one-hot mode outputs plus a level reset for the counter stage.
// Latency: mode and reset outputs change DEBOUNCE_CYCLES+2 edges after a clean raw change; a pause toggle takes one edge more.
// Backpressure: none. Outputs are registered levels, updated every cycle and always exactly one-hot.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic regular_mode,
  output logic adjust_seconds_mode,
  output logic adjust_minutes_mode,
  output logic pause_mode,
  output logic stopwatch_rst
);

  // Channel positions inside the packed per-channel vectors.
  localparam int NCH      = 4;
  localparam int CH_PAUSE = 0;
  localparam int CH_RESET = 1;
  localparam int CH_ADJ   = 2;
  localparam int CH_SEL   = 3;

  // Last count value before a differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q;
  logic [NCH-1:0]   s2_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  logic pause_prev_q;
  logic pause_press;
  logic paused_q;
  logic paused_d;

  logic regular_q, regular_d;
  logic adj_sec_q, adj_sec_d;
  logic adj_min_q, adj_min_d;
  logic pause_q,   pause_d;
  logic swrst_q;

  assign raw = {sw_sel, sw_adj, btn_reset, btn_pause};

  // Two-flop synchroniser on every raw asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Debounce next state: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive samples that differ from the current stable level; any
  // sample matching the stable level restarts the qualification.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_TERM) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers; reset aborts any qualification in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Only the press (0 to 1) of the debounced pause button matters.
  assign pause_press = stable_q[CH_PAUSE] & ~pause_prev_q;

  // Paused flag: the reset button dominates, presses during adjust are dropped.
  always_comb begin
    paused_d = paused_q;
    if (stable_q[CH_RESET]) begin
      paused_d = 1'b0;
    end else if (pause_press && !stable_q[CH_ADJ]) begin
      paused_d = ~paused_q;
    end
  end

  // Pause edge history and the paused flag itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_prev_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      pause_prev_q <= stable_q[CH_PAUSE];
      paused_q     <= paused_d;
    end
  end

  // Mode decode in priority order: adjust first, then pause, else regular.
  // Every branch sets exactly one bit, so the registered outputs stay one-hot.
  always_comb begin
    regular_d = 1'b0;
    adj_sec_d = 1'b0;
    adj_min_d = 1'b0;
    pause_d   = 1'b0;
    if (stable_q[CH_ADJ]) begin
      if (stable_q[CH_SEL]) begin
        adj_min_d = 1'b1;
      end else begin
        adj_sec_d = 1'b1;
      end
    end else if (paused_q) begin
      pause_d = 1'b1;
    end else begin
      regular_d = 1'b1;
    end
  end

  // Registered outputs; during reset the counter is held in reset and shown as regular.
  always_ff @(posedge clk) begin
    if (rst) begin
      regular_q <= 1'b1;
      adj_sec_q <= 1'b0;
      adj_min_q <= 1'b0;
      pause_q   <= 1'b0;
      swrst_q   <= 1'b1;
    end else begin
      regular_q <= regular_d;
      adj_sec_q <= adj_sec_d;
      adj_min_q <= adj_min_d;
      pause_q   <= pause_d;
      swrst_q   <= stable_q[CH_RESET];
    end
  end

  assign regular_mode        = regular_q;
  assign adjust_seconds_mode = adj_sec_q;
  assign adjust_minutes_mode = adj_min_q;
  assign pause_mode          = pause_q;
  assign stopwatch_rst       = swrst_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner with DEBOUNCE_CYCLES=4.
// Each driven cycle pushes its hand-computed expected outputs into a queue;
// an independent monitor pops one entry per cycle and compares.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_pause = 1'b0;
  logic btn_reset = 1'b0;
  logic sw_adj = 1'b0;
  logic sw_sel = 1'b0;
  logic regular_mode;
  logic adjust_seconds_mode;
  logic adjust_minutes_mode;
  logic pause_mode;
  logic stopwatch_rst;

  // Expected vector layout: {regular, adjust_seconds, adjust_minutes, pause, stopwatch_rst}
  localparam logic [4:0] REG  = 5'b10000;
  localparam logic [4:0] ASEC = 5'b01000;
  localparam logic [4:0] AMIN = 5'b00100;
  localparam logic [4:0] PAU  = 5'b00010;
  localparam logic [4:0] SRST = 5'b00001;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [4:0] exp_q[$];
  string name_q[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pause(btn_pause),
    .btn_reset(btn_reset),
    .sw_adj(sw_adj),
    .sw_sel(sw_sel),
    .regular_mode(regular_mode),
    .adjust_seconds_mode(adjust_seconds_mode),
    .adjust_minutes_mode(adjust_minutes_mode),
    .pause_mode(pause_mode),
    .stopwatch_rst(stopwatch_rst)
  );

  always #5 clk = ~clk;

  // Drive one set of inputs for n cycles; exp is the output after each of those edges.
  task automatic drive(input string nm, input int n, input logic r, input logic p,
                       input logic br, input logic a, input logic s, input logic [4:0] exp);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      rst = r;
      btn_pause = p;
      btn_reset = br;
      sw_adj = a;
      sw_sel = s;
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
  endtask

  // Monitor: compares outputs half a cycle after each active edge.
  initial begin : monitor
    logic [4:0] got;
    logic [4:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode, stopwatch_rst};
        checks++;
        step_no++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s step %0d: outputs got %b expected %b", nm, step_no, got, e);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset: held for 3 cycles, counter reset visible, released one cycle later.
    drive("reset_hold",    3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, REG | SRST);
    drive("reset_release", 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);

    // Bounce rejection: 1,0,1,0 in 2-cycle runs never qualifies.
    drive("bounce_1a", 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG);
    drive("bounce_0a", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);
    drive("bounce_1b", 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG);
    drive("bounce_0b", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);
    // Final steady press: pause shows at the 7th edge after its first sample.
    drive("bounce_hold_pre",  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG);
    drive("bounce_hold_post", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PAU);
    drive("bounce_release",  10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PAU);

    // Return to a clean unpaused state.
    drive("rst_between1", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, REG | SRST);
    drive("idle1",        3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);

    // Pause toggle: two clean presses of 10 cycles with 10-cycle gaps.
    drive("press1_pre",  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG);
    drive("press1_post", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PAU);
    drive("gap1",       10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PAU);
    drive("press2_pre",  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PAU);
    drive("press2_post", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG);
    drive("gap2",       10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);

    // Adjust priority: get paused first.
    drive("adj_pause_pre",  7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG);
    drive("adj_pause_post", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PAU);
    drive("adj_pause_rel", 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PAU);
    // Adjust minutes takes over at edge 6.
    drive("adj_min_pre",  6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PAU);
    drive("adj_min_post", 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, AMIN);
    // Select seconds.
    drive("adj_sec_pre",  6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AMIN);
    drive("adj_sec_post", 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ASEC);
    // Pause press while adjusting is discarded.
    drive("adj_press",   10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ASEC);
    drive("adj_release", 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ASEC);
    // Leaving adjust restores the retained paused state.
    drive("adj_exit_pre",  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ASEC);
    drive("adj_exit_post", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PAU);

    // Reset vs pause: clear paused, then both buttons rise together.
    drive("rst_between2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, REG | SRST);
    drive("idle2",        3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);
    drive("rvp_hold_pre",  6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, REG);
    drive("rvp_hold_post", 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, REG | SRST);
    drive("rvp_rel_pre",   6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG | SRST);
    drive("rvp_rel_post",  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);

    // rst in the middle of qualifying btn_reset restarts the count.
    drive("mid_pre_rst",  3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, REG);
    drive("mid_rst",      1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, REG | SRST);
    drive("mid_hold_pre", 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, REG);
    drive("mid_hold_post",4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, REG | SRST);
    drive("mid_rel_pre",  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG | SRST);
    drive("mid_rel_post", 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REG);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
